register_file_1r_1w_multirow: RTL and testbench

Latch-based standard-cell memory with one registered-address read port and one clock-gated write port. It generalises the single-row latch register to NUM_WORDS rows with per-byte write enables. Each row-byte latch bank is driven by its own `tc_clk_gating` instance. It serves as the small, low-power storage primitive for register files, tag arrays and instruction buffers in cluster and core designs, where a flop-based array is too costly in area or power.

---
 rtl/register_file_1r_1w_multirow.sv | 216 +++++++++++++++++++++
 tb/tb_register_file_1r_1w_multirow.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_1r_1w_multirow.sv
//------------------------------------------------------------------------------
// register_file_1r_1w_multirow
//
// Latch-based standard-cell memory. It has NUM_WORDS rows of DATA_WIDTH bits,
// one read port and one write port.
//
// Write port:
//   Write data is captured into the flop WDataQ on the edge that accepts the
//   request. Every row-byte latch bank has its own clock gate (tc_clk_gating).
//   That gate opens for the high phase after the accepting edge, so the
//   addressed latches go transparent while WDataQ is stable. Outside a write
//   no row clock toggles, which is where the power saving comes from.
//
// Read port:
//   The read address is registered into RAddrQ. ReadData is the row selected by
//   RAddrQ. ReadData is forced to zero when the address is out of range, or
//   before the first read after reset (RArmQ).
//
// Optional feature, selected by the macro SCM_READ_OUTPUT_REG_EN:
//   When the macro is defined, ReadData comes from a flop RDataQ, which gives a
//   read latency of two edges. When it is not defined, ReadData is
//   combinational from RAddrQ, which gives a latency of one edge.
//
// Request semantics:
//   A request is a single-cycle strobe. There is no backpressure.
//   - WriteEnable=1 at a posedge commits WriteData/WriteBE to row WriteAddr.
//   - ReadEnable=1 at a posedge captures ReadAddr.
//
// Parameters:
//   DATA_WIDTH  word width, a multiple of 8 (default 32)
//   NUM_WORDS   number of rows, >= 2, any value (default 16)
//   ADDR_WIDTH  derived as $clog2(NUM_WORDS)
//
// Ports:
//   clk          clock, posedge
//   rst_n        asynchronous active-low reset
//   ReadEnable   capture ReadAddr at this posedge
//   ReadAddr     row to read
//   ReadData     content of the captured row
//   WriteEnable  write request this cycle
//   WriteAddr    row to write (values >= NUM_WORDS are ignored by the array)
//   WriteBE      per-byte write enables
//   WriteData    write data
//------------------------------------------------------------------------------

//------------------------------------------------------------------------------
// tc_clk_gating
//
// Behavioural integrated clock gate. It uses a latch that is transparent while
// the clock is low, followed by an AND gate.
//
// Ports:
//   clk_i      input clock
//   en_i       functional enable, sampled while clk_i is low
//   test_en_i  test-mode override enable
//   clk_o      gated clock
//------------------------------------------------------------------------------
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic enLatch;

    // The enable is frozen during the high phase, so clk_o cannot glitch.
    always_latch begin
        if (!clk_i) begin
            enLatch <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & enLatch;

endmodule

module register_file_1r_1w_multirow #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_WORDS  = 16,
    localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      ReadEnable,
    input  logic [ADDR_WIDTH-1:0]     ReadAddr,
    output logic [DATA_WIDTH-1:0]     ReadData,

    input  logic                      WriteEnable,
    input  logic [ADDR_WIDTH-1:0]     WriteAddr,
    input  logic [DATA_WIDTH/8-1:0]   WriteBE,
    input  logic [DATA_WIDTH-1:0]     WriteData
);

    localparam int NB = DATA_WIDTH / 8;

    // Write data staging register
    logic [DATA_WIDTH-1:0] WDataQ;

    // Gated clock for each row-byte, flattened as r*NB + b
    logic [NUM_WORDS*NB-1:0] rowClk;

    // Latch array contents, presented row by row for the read mux
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] rowData;

    // Read side
    logic [ADDR_WIDTH-1:0] RAddrQ;
    logic                  RArmQ;
    logic [DATA_WIDTH-1:0] muxData;

    //--------------------------------------------------------------------------
    // Write data register.
    // Only the enabled bytes load. The latches copy this register during the
    // high phase that follows, while the register is guaranteed stable.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WDataQ <= '0;
        end else if (WriteEnable) begin
            for (int b = 0; b < NB; b++) begin
                if (WriteBE[b]) begin
                    WDataQ[b*8 +: 8] <= WriteData[b*8 +: 8];
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Latch array with one clock gate per row-byte.
    // rst_n is part of the gate enable, so every row clock stays low during
    // reset. Addresses >= NUM_WORDS match no row, so nothing is gated.
    //--------------------------------------------------------------------------
    for (genvar r = 0; r < NUM_WORDS; r++) begin : gRow
        for (genvar b = 0; b < NB; b++) begin : gByte
            logic       gateEn;
            logic [7:0] byteQ;

            assign gateEn = WriteEnable
                          & (WriteAddr == ADDR_WIDTH'(r))
                          & WriteBE[b]
                          & rst_n;

            tc_clk_gating uGate (
                .clk_i     (clk),
                .en_i      (gateEn),
                .test_en_i (1'b0),
                .clk_o     (rowClk[r*NB + b])
            );

            // Storage cell. It is deliberately not reset.
            always_latch begin
                if (rowClk[r*NB + b]) begin
                    byteQ <= WDataQ[b*8 +: 8];
                end
            end

            assign rowData[r][b*8 +: 8] = byteQ;
        end
    end

    //--------------------------------------------------------------------------
    // Read address register and read-armed flag.
    // RArmQ keeps ReadData at zero until the first real read after reset. The
    // latch contents are undefined at that point and must not reach the
    // output.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RAddrQ <= '0;
            RArmQ  <= 1'b0;
        end else if (ReadEnable) begin
            RAddrQ <= ReadAddr;
            RArmQ  <= 1'b1;
        end
    end

    // Row select.
    // Out-of-range rows read as zero. A write to the selected row shows through
    // as soon as the latches go transparent.
    always_comb begin
        muxData = '0;
        if (RArmQ && (32'(RAddrQ) < NUM_WORDS)) begin
            muxData = rowData[RAddrQ];
        end
    end

`ifdef SCM_READ_OUTPUT_REG_EN
    //--------------------------------------------------------------------------
    // Registered read output.
    // RDataQ samples the mux one edge after the address was captured. It holds
    // its value between reads.
    //--------------------------------------------------------------------------
    logic                  readPendQ;
    logic [DATA_WIDTH-1:0] RDataQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readPendQ <= 1'b0;
            RDataQ    <= '0;
        end else begin
            readPendQ <= ReadEnable;
            if (readPendQ) begin
                RDataQ <= muxData;
            end
        end
    end

    assign ReadData = RDataQ;
`else
    // Combinational read output. It is valid before the edge that follows
    // address capture.
    assign ReadData = muxData;
`endif

endmodule

// File: tb/tb_register_file_1r_1w_multirow.sv
//------------------------------------------------------------------------------
// tb_register_file_1r_1w_multirow
//
// Self-checking bench for register_file_1r_1w_multirow. The DUT is configured
// with NUM_WORDS=12, so that out-of-range addresses (12..15) are reachable.
// A reference model of the array pushes the expected read data into expQ when
// each read is issued. The value is popped and compared once the read latency
// has elapsed. Gated-clock pulses are counted against the expected number of
// committed writes.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_register_file_1r_1w_multirow;

    localparam int DW = 32;
    localparam int NW = 12;
    localparam int AW = $clog2(NW);
    localparam int NB = DW / 8;
`ifdef SCM_READ_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ReadEnable = 1'b0;
    logic [AW-1:0] ReadAddr = '0;
    logic [DW-1:0] ReadData;
    logic          WriteEnable = 1'b0;
    logic [AW-1:0] WriteAddr = '0;
    logic [NB-1:0] WriteBE = '0;
    logic [DW-1:0] WriteData = '0;

    always #5 clk = ~clk;

    register_file_1r_1w_multirow #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteBE     (WriteBE),
        .WriteData   (WriteData)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] model [NW];
    logic [1:0]    chkPipe = 2'b00;
    int            checks = 0;
    int            errors = 0;
    int            expPulses = 0;
    int            pulses = 0;
    int            rstPulses = 0;

    // Gated row clocks: every pulse must correspond to a committed write
    wire rowClkAny = |dut.rowClk;
    always @(posedge rowClkAny) begin
        if (!rst_n) rstPulses++;
        else        pulses++;
    end

    task automatic checkVal(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: first compare the read that matured at this negedge, then
    // drive the new request and update the model.
    task automatic step(input logic we, input logic [AW-1:0] wa,
                        input logic [NB-1:0] be, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] e;
        @(negedge clk);
        if (chkPipe[LAT-1]) begin
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = expQ.pop_front();
                checkVal("rdata", ReadData, e);
            end
        end
        chkPipe = {chkPipe[0], 1'b0};
        WriteEnable = we;
        WriteAddr   = wa;
        WriteBE     = be;
        WriteData   = wd;
        ReadEnable  = re;
        ReadAddr    = ra;
        if (we && (32'(wa) < NW)) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) model[wa][b*8 +: 8] = wd[b*8 +: 8];
            if (be != '0) expPulses++;
        end
        if (re) expQ.push_back((32'(ra) < NW) ? model[ra] : '0);
        chkPipe[0] = re;
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] wd);
        step(1'b1, wa, be, wd, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ra);
        step(1'b0, '0, '0, '0, 1'b1, ra);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic readAll();
        for (int r = 0; r < NW; r++) rd(AW'(r));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset with a write request pending: row clocks must stay low
        WriteEnable = 1'b1;
        WriteAddr   = '0;
        WriteBE     = '1;
        WriteData   = 32'hFFFF_FFFF;
        ReadEnable  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("rst_rdata", ReadData, '0);
        end
        @(negedge clk);
        WriteEnable = 1'b0;
        WriteBE     = '0;
        rst_n       = 1'b1;
        ReadEnable  = 1'b1;
        ReadAddr    = '0;
        #1;
        checkVal("unarmed_rdata", ReadData, '0);

        // Initialise every row to zero
        for (int r = 0; r < NW; r++) wr(AW'(r), '1, '0);

        // Full-word write, then read it on the next cycle
        wr(AW'(3), 4'hF, 32'hDEAD_BEEF);
        rd(AW'(3));

        // Partial byte-enable write
        wr(AW'(5), 4'hF, 32'h1122_3344);
        wr(AW'(5), 4'b0101, 32'hAABB_CCDD);
        rd(AW'(5));

        // Same-cycle write and read of row 7 (write-through)
        step(1'b1, AW'(7), 4'hF, 32'hCAFE_F00D, 1'b1, AW'(7));
        readAll();

        // Out-of-range write must not touch the array; out-of-range read is 0
        wr(AW'(13), 4'hF, 32'h5A5A_5A5A);
        readAll();
        rd(AW'(13));

        // A write with WriteBE == 0 is a no-op
        wr(AW'(2), 4'h0, 32'h1234_5678);
        rd(AW'(2));

        // Random mixed traffic, including out-of-range addresses
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 NB'($urandom_range(0, 15)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
        end

        // Fill an index pattern, then reset mid-sequence
        for (int r = 0; r < NW; r++) wr(AW'(r), '1, DW'(32'h0101_0101 * (r + 1)));
        readAll();
        idle(LAT + 1);
        @(negedge clk);
        rst_n       = 1'b0;
        WriteEnable = 1'b1;
        WriteAddr   = AW'(4);
        WriteBE     = '1;
        WriteData   = 32'hFFFF_FFFF;
        ReadEnable  = 1'b1;
        ReadAddr    = AW'(4);
        #1;
        checkVal("rst_mid_rdata0", ReadData, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("rst_mid_rdata", ReadData, '0);
        end
        @(negedge clk);
        WriteEnable = 1'b0;
        WriteBE     = '0;
        ReadEnable  = 1'b0;
        rst_n       = 1'b1;
        readAll();
        idle(LAT + 2);

        checkVal("rst_row_pulses", DW'(rstPulses), '0);
        checkVal("row_pulses", DW'(pulses), DW'(expPulses));
        checkVal("sb_drained", DW'(expQ.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
